ibias_seq: RTL

- Digital sequencer that drives the bias generator's enable and source-select controls and reports when bias current is valid.
- Sits in the always-on digital domain of the brownout IP, between top-level enable/trim bits and the analog bias generator.
- Waits for the bandgap reference current to be reported good, then allows the bias output to settle.
- Handles source-select changes glitch-free and flags a sticky fault if the bandgap never comes up.

---
 rtl/ibias_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ibias_seq.sv
`default_nettype none
// ============================================================================
// Module   : ibias_seq
// Brief    : Bias generator sequencer: bandgap wait, settle, glitch-free
//            source switching and sticky bandgap-timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
module ibias_seq #(
    parameter int SETTLE_CYC = 64,
    parameter int SWITCH_CYC = 16,
    parameter int BG_TIMEOUT = 1024,
    parameter int CNT_W      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       isrc_sel_req,
    input  logic       ibg_ok,
    output logic       ibias_ena,
    output logic       isrc_sel,
    output logic       ibias_rdy,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_BG_WAIT = 3'd1,
        S_SETTLE  = 3'd2,
        S_READY   = 3'd3,
        S_SWITCH  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_SWITCH_LAST = CNT_W'(SWITCH_CYC - 1);
    localparam logic [CNT_W-1:0] C_BG_LAST     = CNT_W'(BG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_sync1, r_sync2;
    logic             r_sel, w_sel_nxt;
    logic             r_ibias_ena, r_ibias_rdy, r_fault;

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // ibg_ok is asynchronous to clk; only the second flop is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ibg_ok;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        if (!ena) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_BG_WAIT;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = isrc_sel_req;
                end
                S_BG_WAIT: begin
                    if (r_sync2) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= C_BG_LAST) begin
                        w_state_nxt = S_FAULT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_BG_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= C_SETTLE_LAST) begin
                        w_state_nxt = S_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_READY: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_BG_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (isrc_sel_req != r_sel) begin
                        w_state_nxt = S_SWITCH;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = isrc_sel_req;
                    end
                end
                S_SWITCH: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_BG_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= C_SWITCH_LAST) begin
                        w_state_nxt = S_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the transition that causes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OFF;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_ibias_ena <= 1'b0;
            r_ibias_rdy <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_ibias_ena <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_READY) ||
                           (w_state_nxt == S_SWITCH);
            r_ibias_rdy <= (w_state_nxt == S_READY);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign ibias_ena = r_ibias_ena;
    assign isrc_sel  = r_sel;
    assign ibias_rdy = r_ibias_rdy;
    assign fault     = r_fault;
    assign state     = r_state;

endmodule
`default_nettype wire
